aud_recorder_param: RTL and testbench

Parametrised I2S capture engine for the audio codec ADC path, the next-generation recorder used by the lab3 top level. It deserialises codec ADC bits on the bit clock, packs them into `DATA_W`-bit words in mono or interleaved-stereo mode, and emits one-cycle SRAM write strobes with address. It supports start/pause/resume/stop, a configurable memory limit, and reports recorded length and error flags back to the controller.

---
 rtl/aud_pkg.sv | 14 +
 rtl/aud_i2s_deser.sv | 54 +++++
 rtl/aud_recorder_param.sv | 153 +++++++++++++++
 tb/tb_aud_recorder_param.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aud_pkg.sv
// rtl/aud_pkg.sv - shared types and defaults for the audio recorder
package aud_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_PAUSE = 2'd2,
        ST_FULL  = 2'd3
    } rec_state_e;

    localparam int DATA_W_DEFAULT = 16;
    localparam int ADDR_W_DEFAULT = 20;

endpackage

// File: rtl/aud_i2s_deser.sv
// rtl/aud_i2s_deser.sv - I2S lrc edge detect, bit counter and MSB-first shift register
module aud_i2s_deser #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              rise_en,
    input  logic              fall_en,
    input  logic              lrc,
    input  logic              data,
    output logic              rise,
    output logic              word_valid,
    output logic              short_frame,
    output logic [DATA_W-1:0] word
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic             lrc_r;
    logic             fall;
    logic             trig;
    logic [CNT_W-1:0] bitcnt;

    assign rise        = !lrc_r && lrc;
    assign fall        = lrc_r && !lrc;
    assign trig        = enable && ((rise && rise_en) || (fall && fall_en));
    assign short_frame = trig && (bitcnt != '0);

    // MSB arrives first, so after DATA_W shifts the word is fully aligned;
    // word is not touched again until the next capture's first bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lrc_r      <= 1'b0;
            bitcnt     <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            lrc_r      <= lrc;
            word_valid <= 1'b0;
            if (!enable) begin
                bitcnt <= '0;
            end else if (trig) begin
                bitcnt <= CNT_W'(DATA_W);
            end else if (bitcnt != '0) begin
                word   <= {word[DATA_W-2:0], data};
                bitcnt <= bitcnt - 1'b1;
                if (bitcnt == CNT_W'(1))
                    word_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/aud_recorder_param.sv
// rtl/aud_recorder_param.sv - I2S ADC capture engine with SRAM write strobes and record FSM
module aud_recorder_param
    import aud_pkg::*;
#(
    parameter int                DATA_W   = DATA_W_DEFAULT,
    parameter int                ADDR_W   = ADDR_W_DEFAULT,
    parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}}
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_lrc,
    input  logic              i_data,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_stereo,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_address,
    output logic [DATA_W-1:0] o_data,
    output logic [ADDR_W:0]   o_length,
    output logic [1:0]        o_state,
    output logic              o_full,
    output logic              o_err
);

    rec_state_e        state;
    rec_state_e        next_state;
    logic              pause_r;
    logic              pause_edge;
    logic              stereo_r;
    logic              armed;
    logic              enable;
    logic              we;
    logic              full_hit;
    logic              start_rec;
    logic              lrc_rise;
    logic              word_valid;
    logic              short_frame;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   length;
    logic              full_r;
    logic              err_r;

    // Falling edges only trigger once a rise has been seen in this WRITE
    // stint, which keeps channel 0 on even addresses after start or resume.
    aud_i2s_deser #(
        .DATA_W(DATA_W)
    ) u_deser (
        .clk        (i_clk),
        .rst        (i_rst),
        .enable     (enable),
        .rise_en    (1'b1),
        .fall_en    (stereo_r && armed),
        .lrc        (i_lrc),
        .data       (i_data),
        .rise       (lrc_rise),
        .word_valid (word_valid),
        .short_frame(short_frame),
        .word       (o_data)
    );

    assign pause_edge = i_pause && !pause_r;
    assign full_hit   = we && (addr == MAX_ADDR);
    assign start_rec  = (state == ST_IDLE) && (next_state == ST_WRITE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (!i_stop && i_start)
                    next_state = ST_WRITE;
            end
            ST_WRITE: begin
                if (i_stop)
                    next_state = ST_IDLE;
                else if (full_hit)
                    next_state = ST_FULL;
                else if (pause_edge)
                    next_state = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (i_stop)
                    next_state = ST_IDLE;
                else if (i_start || pause_edge)
                    next_state = ST_WRITE;
            end
            ST_FULL: begin
                if (i_stop)
                    next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // A word completing just as the FSM leaves WRITE is dropped here.
    always_comb begin
        enable = (state == ST_WRITE);
        we     = word_valid && (state == ST_WRITE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pause_r  <= 1'b0;
            stereo_r <= 1'b0;
            armed    <= 1'b0;
            addr     <= '0;
            length   <= '0;
            full_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            pause_r <= i_pause;

            if (state != ST_WRITE)
                armed <= 1'b0;
            else if (lrc_rise)
                armed <= 1'b1;

            if (next_state == ST_IDLE)
                addr <= '0;
            else if (we && (addr != MAX_ADDR))
                addr <= addr + 1'b1;

            if (start_rec) begin
                stereo_r <= i_stereo;
                length   <= '0;
                full_r   <= 1'b0;
                err_r    <= 1'b0;
            end else begin
                if (we)
                    length <= length + 1'b1;
                if (full_hit && !i_stop)
                    full_r <= 1'b1;
                if (short_frame)
                    err_r <= 1'b1;
            end
        end
    end

    assign o_we      = we;
    assign o_address = addr;
    assign o_length  = length;
    assign o_state   = state;
    assign o_full    = full_r;
    assign o_err     = err_r;

endmodule

// File: tb/tb_aud_recorder_param.sv
// tb/tb_aud_recorder_param.sv - scoreboard bench for aud_recorder_param
module tb_aud_recorder_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lrc = 1'b0;
    logic        data = 1'b0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        stop = 1'b0;
    logic        stereo = 1'b0;
    logic        we;
    logic [3:0]  address;
    logic [15:0] wdata;
    logic [4:0]  length;
    logic [1:0]  state;
    logic        full;
    logic        err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit prev_we = 1'b0;

    typedef struct {
        logic [3:0]  a;
        logic [15:0] d;
        int          c;
    } exp_t;
    exp_t q[$];

    aud_recorder_param #(
        .DATA_W  (16),
        .ADDR_W  (4),
        .MAX_ADDR(4'd5)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_lrc    (lrc),
        .i_data   (data),
        .i_start  (start),
        .i_pause  (pause),
        .i_stop   (stop),
        .i_stereo (stereo),
        .o_we     (we),
        .o_address(address),
        .o_data   (wdata),
        .o_length (length),
        .o_state  (state),
        .o_full   (full),
        .o_err    (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (we) begin
                chk("we_not_back_to_back", {31'd0, prev_we}, 32'd0);
                if (q.size() == 0) begin
                    chk("unexpected_we_addr", {28'd0, address}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("wr_addr", {28'd0, address}, {28'd0, e.a});
                    chk("wr_data", {16'd0, wdata}, {16'd0, e.d});
                    chk("wr_cycle", cyc, e.c);
                end
            end
            prev_we = we;
        end else begin
            prev_we = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic half(input logic lvl, input logic [15:0] w, input int len,
                        input bit exp_w, input logic [3:0] a, input int pulse_at);
        for (int i = 0; i < len; i++) begin
            lrc  = lvl;
            data = (i >= 1 && i <= 16) ? w[16-i] : 1'b0;
            pause = (pulse_at >= 0 && i >= pulse_at && i < pulse_at + 2);
            if (i == 0 && exp_w)
                q.push_back('{a: a, d: w, c: cyc + 17});
            step();
        end
        pause = 1'b0;
    endtask

    task automatic start_rec(input logic s);
        stereo = s;
        start  = 1'b1;
        step();
        start  = 1'b0;
        step();
    endtask

    task automatic stop_rec();
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        repeat (3) step();
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_we", {31'd0, we}, 32'd0);
        chk("rst_len", {27'd0, length}, 32'd0);
        chk("rst_data", {16'd0, wdata}, 32'd0);
        rst = 1'b0;
        step();

        // mono: three frames
        start_rec(1'b0);
        chk("mono_state", {30'd0, state}, 32'd1);
        half(1'b1, 16'hA5C3, 20, 1'b1, 4'd0, -1);
        half(1'b0, 16'h0000, 3, 1'b0, 4'd0, -1);
        half(1'b1, 16'h0001, 20, 1'b1, 4'd1, -1);
        half(1'b0, 16'h0000, 3, 1'b0, 4'd0, -1);
        half(1'b1, 16'hFFFF, 20, 1'b1, 4'd2, -1);
        half(1'b0, 16'h0000, 3, 1'b0, 4'd0, -1);
        chk("mono_len", {27'd0, length}, 32'd3);
        chk("mono_err", {31'd0, err}, 32'd0);
        stop_rec();
        chk("stop_state", {30'd0, state}, 32'd0);
        chk("stop_len_held", {27'd0, length}, 32'd3);
        chk("mono_pending", q.size(), 32'd0);

        // stereo: unarmed fall ignored, L to even, R to odd
        half(1'b1, 16'h0000, 10, 1'b0, 4'd0, -1);
        start_rec(1'b1);
        half(1'b1, 16'h0000, 3, 1'b0, 4'd0, -1);
        half(1'b0, 16'hBEEF, 20, 1'b0, 4'd0, -1);
        half(1'b1, 16'h1234, 20, 1'b1, 4'd0, -1);
        half(1'b0, 16'h8000, 20, 1'b1, 4'd1, -1);
        chk("stereo_len", {27'd0, length}, 32'd2);
        stop_rec();
        chk("stereo_pending", q.size(), 32'd0);

        // pause mid-word, hold, resume
        start_rec(1'b0);
        half(1'b1, 16'h1111, 20, 1'b1, 4'd0, -1);
        half(1'b0, 16'h0000, 3, 1'b0, 4'd0, -1);
        half(1'b1, 16'h2222, 20, 1'b0, 4'd0, 8);
        chk("pause_state", {30'd0, state}, 32'd2);
        half(1'b0, 16'h0000, 20, 1'b0, 4'd0, -1);
        half(1'b1, 16'h3333, 20, 1'b0, 4'd0, -1);
        half(1'b0, 16'h0000, 20, 1'b0, 4'd0, 5);
        chk("resume_state", {30'd0, state}, 32'd1);
        half(1'b1, 16'h4444, 20, 1'b1, 4'd1, -1);
        half(1'b0, 16'h0000, 3, 1'b0, 4'd0, -1);
        chk("pause_len", {27'd0, length}, 32'd2);
        chk("pause_err", {31'd0, err}, 32'd0);
        stop_rec();
        chk("pause_pending", q.size(), 32'd0);

        // fill to MAX_ADDR=5
        start_rec(1'b0);
        for (int k = 0; k < 7; k++) begin
            half(1'b1, 16'h0100 + 16'(k), 18, (k < 6), 4'(k), -1);
            half(1'b0, 16'h0000, 2, 1'b0, 4'd0, -1);
        end
        chk("full_state", {30'd0, state}, 32'd3);
        chk("full_flag", {31'd0, full}, 32'd1);
        chk("full_len", {27'd0, length}, 32'd6);
        stop_rec();
        chk("full_stop_state", {30'd0, state}, 32'd0);
        chk("full_stop_len", {27'd0, length}, 32'd6);
        chk("full_stop_flag", {31'd0, full}, 32'd1);
        chk("full_pending", q.size(), 32'd0);

        // short frame: next rise arrives with one bit still missing
        start_rec(1'b0);
        chk("start_clears_full", {31'd0, full}, 32'd0);
        half(1'b1, 16'hDEAD, 8, 1'b0, 4'd0, -1);
        half(1'b0, 16'h0000, 8, 1'b0, 4'd0, -1);
        half(1'b1, 16'h5A5A, 20, 1'b1, 4'd0, -1);
        half(1'b0, 16'h0000, 3, 1'b0, 4'd0, -1);
        chk("short_err", {31'd0, err}, 32'd1);
        chk("short_len", {27'd0, length}, 32'd1);
        stop_rec();
        chk("short_pending", q.size(), 32'd0);

        // stop and pause edge together
        start_rec(1'b0);
        chk("restart_err_clear", {31'd0, err}, 32'd0);
        half(1'b1, 16'h7777, 10, 1'b0, 4'd0, -1);
        stop  = 1'b1;
        pause = 1'b1;
        step();
        stop  = 1'b0;
        step();
        pause = 1'b0;
        chk("stop_pause_state", {30'd0, state}, 32'd0);
        half(1'b1, 16'h7777, 15, 1'b0, 4'd0, -1);
        half(1'b0, 16'h0000, 3, 1'b0, 4'd0, -1);
        chk("stop_pause_len", {27'd0, length}, 32'd0);
        chk("stop_pause_pending", q.size(), 32'd0);

        // async reset mid-word
        start_rec(1'b0);
        half(1'b1, 16'h0F0F, 20, 1'b1, 4'd0, -1);
        half(1'b0, 16'h0000, 3, 1'b0, 4'd0, -1);
        chk("pre_rst_len", {27'd0, length}, 32'd1);
        half(1'b1, 16'h3C3C, 8, 1'b0, 4'd0, -1);
        rst = 1'b1;
        #2;
        chk("arst_state", {30'd0, state}, 32'd0);
        chk("arst_len", {27'd0, length}, 32'd0);
        chk("arst_data", {16'd0, wdata}, 32'd0);
        chk("arst_addr", {28'd0, address}, 32'd0);
        chk("arst_we", {31'd0, we}, 32'd0);
        step();
        step();
        rst = 1'b0;
        half(1'b1, 16'h0000, 20, 1'b0, 4'd0, -1);
        chk("post_rst_state", {30'd0, state}, 32'd0);
        chk("post_rst_pending", q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
